pwm_compare: RTL and testbench

PWM_COMPARE -- requirements
Module: pwm_compare

---
 rtl/pwm_compare.sv | 83 ++++++++
 tb/tb_pwm_compare.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_compare.sv
// PWM comparator driven by an external 8-bit up-counter. A duty value is
// handshaked into a shadow register and moved to the active compare value only at period boundaries.
module pwm_compare (
    input  logic        clk,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  count,
    input  logic [7:0]  duty_in,
    input  logic        duty_valid,
    output logic        duty_ready,
    output logic        pwm_out,
    output logic        period_done,
    output logic [15:0] period_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  shadow_q, shadow_d;
    logic        pending_q, pending_d;
    logic [7:0]  active_q, active_d;
    logic        pwm_q, pwm_d;
    logic        done_q, done_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic        accept;
    logic        xfer;

    assign duty_ready  = ~pending_q & ~clear;
    assign pwm_out     = pwm_q;
    assign period_done = done_q;
    assign period_cnt  = pcnt_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = ARMED;
            ARMED:   if (!en) state_d = IDLE;
                     else if (count == 8'h00) state_d = RUN;
            RUN:     if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        accept = duty_valid & duty_ready;
        xfer   = pending_q & ((state_q != RUN) | (count == 8'hFF));

        // A value accepted alongside a transfer lands in shadow only; active takes the old shadow.
        shadow_d  = accept ? duty_in : shadow_q;
        active_d  = xfer ? shadow_q : active_q;
        pending_d = pending_q;
        if (xfer)   pending_d = 1'b0;
        if (accept) pending_d = 1'b1;

        // Compare on the edge entering RUN too, so count 0 of the first period is covered.
        pwm_d  = (state_d == RUN) && (count < active_q);
        done_d = (state_q == RUN) && en && (count == 8'hFF);
        pcnt_d = pcnt_q + {15'd0, done_d};
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= IDLE;
            shadow_q  <= 8'h00;
            pending_q <= 1'b0;
            active_q  <= 8'h00;
            pwm_q     <= 1'b0;
            done_q    <= 1'b0;
            pcnt_q    <= 16'h0000;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            pwm_q     <= pwm_d;
            done_q    <= done_d;
            pcnt_q    <= pcnt_d;
        end
    end

endmodule

// File: tb/tb_pwm_compare.sv
// Directed bench for pwm_compare: the bench drives the upstream count itself
// and checks waveform, handshake and period bookkeeping against hand-computed values.
module tb_pwm_compare;

    logic        clk = 1'b0;
    logic        clear;
    logic        en;
    logic [7:0]  count;
    logic [7:0]  duty_in;
    logic        duty_valid;
    logic        duty_ready;
    logic        pwm_out;
    logic        period_done;
    logic [15:0] period_cnt;

    int checks = 0;
    int errors = 0;
    int exp_pcnt = 0;

    pwm_compare dut (
        .clk        (clk),
        .clear      (clear),
        .en         (en),
        .count      (count),
        .duty_in    (duty_in),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .pwm_out    (pwm_out),
        .period_done(period_done),
        .period_cnt (period_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full period, count 0..255, with up to two single-cycle duty offers.
    task automatic sweep(input int ia, input logic [7:0] av, input int ib, input logic [7:0] bv,
                         output int highs, output int dones, output int first_hi,
                         output int rdy_low, output logic last_pwm);
        highs = 0; dones = 0; first_hi = -1; rdy_low = 0; last_pwm = 1'b0;
        for (int c = 0; c < 256; c++) begin
            count      = 8'(c);
            duty_valid = (c == ia) || (c == ib);
            duty_in    = (c == ia) ? av : bv;
            #1;
            if (!duty_ready) rdy_low++;
            tick();
            if (pwm_out) begin
                if (first_hi < 0) first_hi = c;
                highs++;
            end
            if (period_done) dones++;
            last_pwm = pwm_out;
        end
        duty_valid = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1; en = 1'b1; duty_valid = 1'b1; duty_in = 8'h55; count = 8'h00;
        #1;
        checks++;
        if (duty_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_during_clear: got %b want 0", duty_ready);
        end
        tick();
        count = 8'h01;
        tick();
        checks++;
        if (pwm_out !== 1'b0 || period_done !== 1'b0 || period_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: pwm=%b done=%b pcnt=%h want 0/0/0000", pwm_out, period_done, period_cnt);
        end
        clear = 1'b0; en = 1'b0; duty_valid = 1'b0;
        #1;
        checks++;
        if (duty_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_after: got %b want 1", duty_ready);
        end
    endtask

    task automatic test_basic();
        int h, d, f, r; logic lp;
        count = 8'h30; duty_in = 8'h40; duty_valid = 1'b1;
        tick();
        duty_valid = 1'b0;
        tick();
        en = 1'b1; count = 8'hFE;
        tick();
        count = 8'hFF;
        tick();
        checks++;
        if (pwm_out !== 1'b0 || period_done !== 1'b0) begin
            errors++; $display("FAIL basic_armed: pwm=%b done=%b want 0/0", pwm_out, period_done);
        end
        sweep(-1, 8'h00, -1, 8'h00, h, d, f, r, lp);
        exp_pcnt++;
        checks++;
        if (h != 64 || f != 0) begin
            errors++; $display("FAIL basic_highs: highs=%0d first=%0d want 64/0", h, f);
        end
        checks++;
        if (d != 1 || period_cnt !== 16'(exp_pcnt)) begin
            errors++; $display("FAIL basic_period: dones=%0d pcnt=%0d want 1/%0d", d, period_cnt, exp_pcnt);
        end
    endtask

    task automatic test_shadow();
        int h, d, f, r; logic lp;
        sweep(8'h20, 8'h80, -1, 8'h00, h, d, f, r, lp);
        exp_pcnt++;
        checks++;
        if (h != 64) begin
            errors++; $display("FAIL shadow_load80_old_period: highs=%0d want 64", h);
        end
        sweep(8'h20, 8'h10, -1, 8'h00, h, d, f, r, lp);
        exp_pcnt++;
        checks++;
        if (h != 128 || d != 1) begin
            errors++; $display("FAIL shadow_current_period: highs=%0d dones=%0d want 128/1", h, d);
        end
        checks++;
        if (r != 223) begin
            errors++; $display("FAIL shadow_ready_low: cycles=%0d want 223", r);
        end
        sweep(-1, 8'h00, -1, 8'h00, h, d, f, r, lp);
        exp_pcnt++;
        checks++;
        if (h != 16 || r != 0) begin
            errors++; $display("FAIL shadow_next_period: highs=%0d ready_low=%0d want 16/0", h, r);
        end
    endtask

    task automatic test_boundary();
        int h, d, f, r; logic lp;
        sweep(5, 8'h00, -1, 8'h00, h, d, f, r, lp);
        exp_pcnt++;
        sweep(5, 8'hFF, -1, 8'h00, h, d, f, r, lp);
        exp_pcnt++;
        checks++;
        if (h != 0) begin
            errors++; $display("FAIL boundary_duty00: highs=%0d want 0", h);
        end
        sweep(-1, 8'h00, -1, 8'h00, h, d, f, r, lp);
        exp_pcnt++;
        checks++;
        if (h != 255 || lp !== 1'b0) begin
            errors++; $display("FAIL boundary_dutyFF: highs=%0d pwm_at_ff=%b want 255/0", h, lp);
        end
    endtask

    task automatic test_back_to_back();
        int h, d, f, r; logic lp;
        sweep(8'h10, 8'hA0, 8'h11, 8'hB0, h, d, f, r, lp);
        exp_pcnt++;
        checks++;
        if (h != 255 || r != 239) begin
            errors++; $display("FAIL backpressure_period: highs=%0d ready_low=%0d want 255/239", h, r);
        end
        sweep(-1, 8'h00, -1, 8'h00, h, d, f, r, lp);
        exp_pcnt++;
        checks++;
        if (h != 160) begin
            errors++; $display("FAIL backpressure_captured: highs=%0d want 160 (A0)", h);
        end
        checks++;
        if (period_cnt !== 16'(exp_pcnt)) begin
            errors++; $display("FAIL pcnt_after_runs: got %0d want %0d", period_cnt, exp_pcnt);
        end
    endtask

    task automatic test_abort();
        int h, d, f, r; logic lp;
        int dn = 0, hi = 0;
        for (int c = 0; c < 8'h80; c++) begin
            count = 8'(c);
            tick();
        end
        count = 8'h80; en = 1'b0;
        tick();
        checks++;
        if (pwm_out !== 1'b0 || period_done !== 1'b0) begin
            errors++; $display("FAIL abort_next_cycle: pwm=%b done=%b want 0/0", pwm_out, period_done);
        end
        for (int c = 8'h81; c < 8'h90; c++) begin
            count = 8'(c);
            tick();
            if (period_done) dn++;
        end
        en = 1'b1;
        for (int c = 8'h90; c < 256; c++) begin
            count = 8'(c);
            tick();
            if (period_done) dn++;
            if (pwm_out) hi++;
        end
        checks++;
        if (dn != 0 || hi != 0 || period_cnt !== 16'(exp_pcnt)) begin
            errors++;
            $display("FAIL abort_no_pulse: dones=%0d highs=%0d pcnt=%0d want 0/0/%0d", dn, hi, period_cnt, exp_pcnt);
        end
        sweep(-1, 8'h00, -1, 8'h00, h, d, f, r, lp);
        exp_pcnt++;
        checks++;
        if (h != 160 || f != 0 || d != 1 || period_cnt !== 16'(exp_pcnt)) begin
            errors++;
            $display("FAIL abort_restart: highs=%0d first=%0d dones=%0d pcnt=%0d want 160/0/1/%0d",
                     h, f, d, period_cnt, exp_pcnt);
        end
    endtask

    task automatic test_clear_mid_run();
        int dn = 0, hi = 0;
        for (int c = 0; c < 8'h50; c++) begin
            count = 8'(c);
            tick();
        end
        count = 8'h50; clear = 1'b1; duty_in = 8'h33; duty_valid = 1'b1;
        tick();
        exp_pcnt = 0;
        checks++;
        if (pwm_out !== 1'b0 || period_done !== 1'b0 || period_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL clear_mid_run: pwm=%b done=%b pcnt=%h want 0/0/0000", pwm_out, period_done, period_cnt);
        end
        clear = 1'b0; duty_valid = 1'b0;
        for (int c = 8'h51; c < 256 + 8'h40; c++) begin
            count = 8'(c);
            tick();
            if (period_done) dn++;
            if (pwm_out) hi++;
        end
        // active was cleared and the 8'h33 offer was dropped, so the restarted period stays low.
        checks++;
        if (dn != 0 || hi != 0 || period_cnt !== 16'h0000) begin
            errors++; $display("FAIL clear_restart: dones=%0d highs=%0d pcnt=%0d want 0/0/0", dn, hi, period_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shadow();
        test_boundary();
        test_back_to_back();
        test_abort();
        test_clear_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
